// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: datapath width, memory
// geometry and the response owner encoding.
package mem_port_arbiter_pkg;

  localparam int XLEN            = 32;
  localparam int PART_ADDR_WIDTH = 12;
  localparam int MEM_SIZE        = 4096;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

endpackage

// File: rtl/arb_rsp_tracker.sv
// Response tracker: remembers who owns the access granted last cycle and
// steers the memory read data (or a zero ack / error) back to that master.
module arb_rsp_tracker #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            gnt_i,
  input  logic            owner_i,
  input  logic            err_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            if_err_o,
  output logic            ls_rvalid_o,
  output logic [XLEN-1:0] ls_rdata_o,
  output logic            ls_err_o
);
  import mem_port_arbiter_pkg::*;

  logic            rsp_valid;
  logic            rsp_owner;
  logic            rsp_err;
  logic            rsp_we;
  logic [XLEN-1:0] rsp_data;

  // Capture the grant attributes; an idle cycle clears everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_we    <= 1'b0;
    end else begin
      rsp_valid <= gnt_i;
      rsp_owner <= gnt_i & owner_i;
      rsp_err   <= gnt_i & err_i;
      rsp_we    <= gnt_i & we_i;
    end
  end

  // Only in-range reads return memory data; stores and errors return zero.
  always_comb begin
    rsp_data    = (rsp_valid && !rsp_err && !rsp_we) ? mem_rdata_i : '0;
    if_rvalid_o = rsp_valid && (rsp_owner == OWNER_IF);
    ls_rvalid_o = rsp_valid && (rsp_owner == OWNER_LS);
    if_rdata_o  = if_rvalid_o ? rsp_data : '0;
    ls_rdata_o  = ls_rvalid_o ? rsp_data : '0;
    if_err_o    = if_rvalid_o & rsp_err;
    ls_err_o    = ls_rvalid_o & rsp_err;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared instruction/data memory port.
// Load/store has priority; with ARB_STARVE_GUARD_EN defined, a fetch that
// has been denied MAX_WAIT consecutive cycles is forced to win once.
module mem_port_arbiter #(
  parameter int XLEN      = mem_port_arbiter_pkg::XLEN,
  parameter int ADDR_W    = mem_port_arbiter_pkg::PART_ADDR_WIDTH,
  parameter int MEM_BYTES = mem_port_arbiter_pkg::MEM_SIZE,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  output logic              if_err_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [XLEN-1:0]   ls_addr_i,
  input  logic [XLEN-1:0]   ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [XLEN-1:0]   ls_rdata_o,
  output logic              ls_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);
  import mem_port_arbiter_pkg::*;

  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be within 1..15");
  end

  logic            force_if;
  logic            any_gnt;
  logic [XLEN-1:0] sel_addr;
  logic            sel_in_range;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt;

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 4'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign force_if = if_req_i && (wait_cnt == 4'(MAX_WAIT));
`else
  assign force_if = 1'b0;
`endif

  // Single grant per cycle: ls first unless fetch has waited too long.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (ls_req_i && !force_if) begin
      ls_gnt_o = 1'b1;
    end else if (if_req_i) begin
      if_gnt_o = 1'b1;
    end
  end

  // Drive the memory port from the winner; out-of-range accesses never strobe.
  always_comb begin
    any_gnt      = if_gnt_o | ls_gnt_o;
    sel_addr     = ls_gnt_o ? ls_addr_i : if_addr_i;
    sel_in_range = sel_addr < MEM_LIMIT;
    mem_req_o    = any_gnt & sel_in_range;
    mem_we_o     = ls_gnt_o & ls_we_i & sel_in_range;
    mem_addr_o   = {sel_addr[ADDR_W-1:2], 2'b00};
    mem_wdata_o  = ls_wdata_i;
  end

  arb_rsp_tracker #(
    .XLEN(XLEN)
  ) u_rsp_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gnt_i       (any_gnt),
    .owner_i     (ls_gnt_o ? OWNER_LS : OWNER_IF),
    .err_i       (~sel_in_range),
    .we_i        (ls_gnt_o & ls_we_i),
    .mem_rdata_i (mem_rdata_i),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_err_o    (if_err_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .ls_err_o    (ls_err_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random
// traffic, with a word-array reference memory and a grant model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int WORDS    = MEM_SIZE / 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic                       if_req_i;
  logic [XLEN-1:0]            if_addr_i;
  logic                       if_gnt_o;
  logic                       if_rvalid_o;
  logic [XLEN-1:0]            if_rdata_o;
  logic                       if_err_o;
  logic                       ls_req_i;
  logic                       ls_we_i;
  logic [XLEN-1:0]            ls_addr_i;
  logic [XLEN-1:0]            ls_wdata_i;
  logic                       ls_gnt_o;
  logic                       ls_rvalid_o;
  logic [XLEN-1:0]            ls_rdata_o;
  logic                       ls_err_o;
  logic                       mem_req_o;
  logic                       mem_we_o;
  logic [PART_ADDR_WIDTH-1:0] mem_addr_o;
  logic [XLEN-1:0]            mem_wdata_o;
  logic [XLEN-1:0]            mem_rdata_i;

  mem_port_arbiter #(
    .XLEN(XLEN), .ADDR_W(PART_ADDR_WIDTH), .MEM_BYTES(MEM_SIZE), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous-read memory seen by the DUT; idle cycles present garbage.
  logic [XLEN-1:0] mem [WORDS];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) mem[mem_addr_o[PART_ADDR_WIDTH-1:2]] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o[PART_ADDR_WIDTH-1:2]];
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  // Reference state.
  logic [XLEN-1:0] ref_mem [WORDS];
  int              if_denied = 0;

  typedef struct {
    int          tag;
    bit          owner;
    bit          err;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %b, want %b", name, cyc, act, exp);
  endtask

  // Monitor: compare both response channels every cycle against the queue.
  rsp_t mon_e;
  bit   mon_have;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      mon_have = (exp_q.size() > 0) && (exp_q[0].tag == cyc);
      if (mon_have) mon_e = exp_q.pop_front();
      else mon_e = '{tag: cyc, owner: 1'b0, err: 1'b0, data: 32'h0};
      check_b("if_rvalid", if_rvalid_o, mon_have && mon_e.owner == OWNER_IF);
      check_b("ls_rvalid", ls_rvalid_o, mon_have && mon_e.owner == OWNER_LS);
      check_b("if_err",    if_err_o,    mon_have && mon_e.owner == OWNER_IF && mon_e.err);
      check_b("ls_err",    ls_err_o,    mon_have && mon_e.owner == OWNER_LS && mon_e.err);
      check_w("if_rdata",  if_rdata_o,  (mon_have && mon_e.owner == OWNER_IF) ? mon_e.data : 32'h0);
      check_w("ls_rdata",  ls_rdata_o,  (mon_have && mon_e.owner == OWNER_LS) ? mon_e.data : 32'h0);
    end
  end

  // One cycle of stimulus; returns the grants the DUT actually gave.
  task automatic step(input bit ir, input logic [31:0] ia, input bit lr, input bit lw,
                      input logic [31:0] la, input logic [31:0] ld,
                      output bit ig, output bit lg);
    bit          force_if, eig, elg, inr, is_store;
    logic [31:0] a;
    rsp_t        e;
    if_req_i = ir; if_addr_i = ia;
    ls_req_i = lr; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = ld;
    @(negedge clk_i);
    force_if = GUARD && ir && (if_denied >= MAX_WAIT);
    elg = lr && !force_if;
    eig = ir && !elg;
    check_b("if_gnt", if_gnt_o, eig);
    check_b("ls_gnt", ls_gnt_o, elg);
    ig = if_gnt_o;
    lg = ls_gnt_o;
    if (eig || elg) begin
      a        = elg ? la : ia;
      inr      = a < MEM_SIZE;
      is_store = elg && lw;
      check_b("mem_req", mem_req_o, inr);
      if (inr) begin
        check_w("mem_addr", 32'(mem_addr_o), {20'h0, a[11:2], 2'b00});
        check_b("mem_we", mem_we_o, is_store);
        if (is_store) check_w("mem_wdata", mem_wdata_o, ld);
      end
      e.tag   = cyc + 1;
      e.owner = elg;
      e.err   = !inr;
      e.data  = (inr && !is_store) ? ref_mem[a[11:2]] : 32'h0;
      exp_q.push_back(e);
      if (inr && is_store) ref_mem[a[11:2]] = ld;
    end else begin
      check_b("mem_req_idle", mem_req_o, 1'b0);
    end
    if (ir && !eig) if_denied = (if_denied < MAX_WAIT) ? if_denied + 1 : MAX_WAIT;
    else if_denied = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
    if (r == 1) return 32'(MEM_SIZE) + 32'($urandom_range(0, 255));
    if (r < 8)  return 32'($urandom_range(0, 63));
    return 32'($urandom_range(0, MEM_SIZE - 1));
  endfunction

  initial begin
    bit          g0, g1, ip, lp, lw;
    int          if_wins;
    logic [31:0] ia, la, ld, w;

    for (int i = 0; i < WORDS; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[4] = 32'h0000_0013;
    ref_mem[4] = 32'h0000_0013;
    mem_rdata_i = 32'h0;

    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check_b("rst_if_rvalid", if_rvalid_o, 1'b0);
    check_b("rst_ls_rvalid", ls_rvalid_o, 1'b0);
    check_b("rst_if_err",    if_err_o,    1'b0);
    check_b("rst_ls_err",    ls_err_o,    1'b0);
    check_w("rst_if_rdata",  if_rdata_o,  32'h0);
    check_w("rst_ls_rdata",  ls_rdata_o,  32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(1);

    // Fetch only.
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
    idle(1);

    // Store then load back to back.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, g0, g1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    idle(1);

    // Unaligned fetch.
    step(1'b1, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
    idle(1);

    // Range errors: load at the limit, store just above it.
    w = mem[1];
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'(MEM_SIZE), 32'h0, g0, g1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'(MEM_SIZE) + 32'h4, 32'hA5A5_5A5A, g0, g1);
    idle(1);
    check_w("oor_store_mem1", mem[1], w);

    // Contention with both requests held.
    if_wins = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h40, 1'b1, 1'b0, 32'($urandom_range(0, 255)), 32'h0, g0, g1);
      if (g0) if_wins++;
    end
    check_w("contention_if_wins", 32'(if_wins), GUARD ? 32'd2 : 32'd0);
    idle(1);

    // Reset in the response cycle.
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
    rst_i = 1'b1;
    exp_q.delete();
    if_denied = 0;
    #1;
    check_b("rstmid_if_rvalid", if_rvalid_o, 1'b0);
    check_b("rstmid_ls_rvalid", ls_rvalid_o, 1'b0);
    check_w("rstmid_if_rdata",  if_rdata_o,  32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(3);

    // Random traffic; requests hold until granted.
    ip = 1'b0; lp = 1'b0; lw = 1'b0;
    ia = 32'h0; la = 32'h0; ld = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!ip && $urandom_range(0, 99) < 60) begin
        ip = 1'b1;
        ia = rand_addr();
      end
      if (!lp && $urandom_range(0, 99) < 60) begin
        lp = 1'b1;
        lw = 1'($urandom_range(0, 1));
        la = rand_addr();
        ld = $urandom;
      end
      step(ip, ia, lp, lw, la, ld, g0, g1);
      if (g0) ip = 1'b0;
      if (g1) lp = 1'b0;
    end
    idle(2);

    for (int i = 0; i < WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        check_w("final_mem", mem[i], ref_mem[i]);
        break;
      end
    end
    check_b("queue_drained", exp_q.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
